// File: rtl/debug_trace_buffer_pkg.sv
// debug_trace_pkg: shared FSM state, trace entry layout and word count.
// Entry carries a timestamp only when DEBUG_TRACE_TIMESTAMP_EN is defined.
package debug_trace_pkg;

  typedef enum logic [1:0] {
    ARMED = 2'd0,
    POST  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

`ifdef DEBUG_TRACE_TIMESTAMP_EN
  localparam int unsigned WORDS_PER_ENTRY = 4;

  typedef struct packed {
    logic [31:0] ts;
    logic [31:0] inst;
    logic [31:0] alu_out;
    logic [4:0]  write_reg;
    logic        reg_write;
  } entry_t;
`else
  localparam int unsigned WORDS_PER_ENTRY = 3;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] alu_out;
    logic [4:0]  write_reg;
    logic        reg_write;
  } entry_t;
`endif

  function automatic logic [31:0] ctrl_word(entry_t e);
    return {26'b0, e.reg_write, e.write_reg};
  endfunction

endpackage

// File: rtl/debug_trace_buffer_ram.sv
// trace_ring_ram: DEPTH x entry_t storage, one sync write port, one async read port.
// Ports: clk, we_i/waddr_i/wdata_i write, raddr_i/rdata_o read.
module trace_ring_ram
  import debug_trace_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  entry_t                   wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output entry_t                   rdata_o
);

  entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Combinational read: the drained word is valid the same cycle the
  // pointer moves, so the readout stream never bubbles.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/debug_trace_buffer.sv
// debug_trace_buffer: triggered ring capture of writeback snapshots, word-serial readout.
// Ports: cap_*, trig_*, arm in; rd_valid/rd_data/rd_last/rd_ready out; state_o, count_o. Option: DEBUG_TRACE_TIMESTAMP_EN.
module debug_trace_buffer
  import debug_trace_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned POST_TRIG = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cap_valid,
  input  logic [31:0]            cap_inst,
  input  logic [31:0]            cap_alu_out,
  input  logic [4:0]             cap_write_reg,
  input  logic                   cap_reg_write,
  input  logic [31:0]            trig_inst,
  input  logic [31:0]            trig_mask,
  input  logic                   arm,
  output logic                   rd_valid,
  output logic [31:0]            rd_data,
  output logic                   rd_last,
  input  logic                   rd_ready,
  output logic [1:0]             state_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [PW-1:0] POST_INIT = PW'(POST_TRIG);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [1:0] LAST_WORD = 2'(WORDS_PER_ENTRY - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic [PW-1:0] post_q, post_d;
  logic [1:0]    word_q, word_d;
  logic          we;
  logic          match;
  entry_t        wentry;
  entry_t        rentry;

`ifdef DEBUG_TRACE_TIMESTAMP_EN
  logic [31:0] ts_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_q <= '0;
    else        ts_q <= ts_q + 32'd1;
  end
`endif

  assign match = ((cap_inst ^ trig_inst) & trig_mask) == '0;

  always_comb begin
    wentry           = '0;
    wentry.inst      = cap_inst;
    wentry.alu_out   = cap_alu_out;
    wentry.write_reg = cap_write_reg;
    wentry.reg_write = cap_reg_write;
`ifdef DEBUG_TRACE_TIMESTAMP_EN
    wentry.ts        = ts_q;
`endif
  end

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    post_d  = post_q;
    word_d  = word_q;
    we      = 1'b0;
    if (arm) begin
      state_d = ARMED;
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      post_d  = '0;
      word_d  = '0;
    end else begin
      case (state_q)
        ARMED, POST: begin
          if (cap_valid) begin
            we     = 1'b1;
            wptr_d = wptr_q + 1'b1;
            if (count_q != FULL) count_d = count_q + 1'b1;
            if (state_q == ARMED) begin
              if (match) begin
                if (POST_TRIG == 0) begin
                  state_d = DRAIN;
                end else begin
                  state_d = POST;
                  post_d  = POST_INIT;
                end
              end
            end else begin
              post_d = post_q - 1'b1;
              if (post_q == PW'(1)) state_d = DRAIN;
            end
            // Oldest entry sits count entries behind the write pointer;
            // a full ring wraps this back onto the write pointer.
            rptr_d = wptr_d - count_d[AW-1:0];
          end
        end
        DRAIN: begin
          if (rd_ready) begin
            if (word_q == LAST_WORD) begin
              word_d  = '0;
              rptr_d  = rptr_q + 1'b1;
              count_d = count_q - 1'b1;
              if (count_q == (AW+1)'(1)) state_d = DONE;
            end else begin
              word_d = word_q + 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARMED;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      post_q  <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      post_q  <= post_d;
      word_q  <= word_d;
    end
  end

  trace_ring_ram #(
    .DEPTH(DEPTH)
  ) u_ram (
    .clk    (clk),
    .we_i   (we),
    .waddr_i(wptr_q),
    .wdata_i(wentry),
    .raddr_i(rptr_q),
    .rdata_o(rentry)
  );

  assign rd_valid = (state_q == DRAIN);
  assign rd_last  = rd_valid && (word_q == LAST_WORD)
                    && (count_q == (AW+1)'(1));
  assign state_o  = state_q;
  assign count_o  = count_q;

  always_comb begin
    rd_data = '0;
    if (rd_valid) begin
      case (word_q)
        2'd0:    rd_data = rentry.inst;
        2'd1:    rd_data = rentry.alu_out;
        2'd2:    rd_data = ctrl_word(rentry);
`ifdef DEBUG_TRACE_TIMESTAMP_EN
        2'd3:    rd_data = rentry.ts;
`endif
        default: rd_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_trace_buffer.sv
// tb_debug_trace_buffer: directed + random stimulus against a queue-based model.
// Two DUTs share inputs: POST_TRIG=2 (modelled) and POST_TRIG=0 (directed).
module tb_debug_trace_buffer;

  localparam int DEPTH = 16;
  localparam int PT    = 2;
`ifdef DEBUG_TRACE_TIMESTAMP_EN
  localparam int WPE = 4;
`else
  localparam int WPE = 3;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cap_valid = 1'b0;
  logic [31:0] cap_inst = '0;
  logic [31:0] cap_alu_out = '0;
  logic [4:0]  cap_write_reg = '0;
  logic        cap_reg_write = 1'b0;
  logic [31:0] trig_inst = '0;
  logic [31:0] trig_mask = '0;
  logic        arm = 1'b0;
  logic        rd_ready = 1'b0;

  logic        rd_valid, rd_last;
  logic [31:0] rd_data;
  logic [1:0]  state_o;
  logic [4:0]  count_o;
  logic        b_rd_valid, b_rd_last;
  logic [31:0] b_rd_data;
  logic [1:0]  b_state;
  logic [4:0]  b_count;

  always #5 clk = ~clk;

  debug_trace_buffer #(.DEPTH(DEPTH), .POST_TRIG(PT)) u_dut (
    .clk(clk), .rst_n(rst_n), .cap_valid(cap_valid),
    .cap_inst(cap_inst), .cap_alu_out(cap_alu_out),
    .cap_write_reg(cap_write_reg), .cap_reg_write(cap_reg_write),
    .trig_inst(trig_inst), .trig_mask(trig_mask), .arm(arm),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
    .rd_ready(rd_ready), .state_o(state_o), .count_o(count_o)
  );

  debug_trace_buffer #(.DEPTH(DEPTH), .POST_TRIG(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .cap_valid(cap_valid),
    .cap_inst(cap_inst), .cap_alu_out(cap_alu_out),
    .cap_write_reg(cap_write_reg), .cap_reg_write(cap_reg_write),
    .trig_inst(trig_inst), .trig_mask(trig_mask), .arm(arm),
    .rd_valid(b_rd_valid), .rd_data(b_rd_data), .rd_last(b_rd_last),
    .rd_ready(rd_ready), .state_o(b_state), .count_o(b_count)
  );

  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  typedef struct {
    logic [31:0] inst;
    logic [31:0] alu;
    logic [4:0]  wr;
    logic        rw;
    logic [31:0] ts;
  } ment_t;

  ment_t       hist[$];
  logic [31:0] words[$];
  int          m_st, m_post, m_acc;
  int          checks, errors;

  function automatic void model_reset();
    m_st = 0; m_post = 0; m_acc = 0;
    hist.delete(); words.delete();
  endfunction

  function automatic void enter_drain();
    m_st = 2; m_acc = 0;
    words.delete();
    foreach (hist[i]) begin
      words.push_back(hist[i].inst);
      words.push_back(hist[i].alu);
      words.push_back({26'b0, hist[i].rw, hist[i].wr});
      if (WPE == 4) words.push_back(hist[i].ts);
    end
  endfunction

  function automatic void model_step();
    ment_t e;
    if (arm) begin
      model_reset();
      return;
    end
    if ((m_st == 0 || m_st == 1) && cap_valid) begin
      e.inst = cap_inst; e.alu = cap_alu_out;
      e.wr = cap_write_reg; e.rw = cap_reg_write;
      e.ts = 32'(cyc);
      hist.push_back(e);
      if (hist.size() > DEPTH) void'(hist.pop_front());
      if (m_st == 0) begin
        if ((cap_inst & trig_mask) == (trig_inst & trig_mask)) begin
          if (PT == 0) enter_drain();
          else begin m_st = 1; m_post = PT; end
        end
      end else begin
        m_post--;
        if (m_post == 0) enter_drain();
      end
    end else if (m_st == 2 && rd_ready) begin
      void'(words.pop_front());
      m_acc++;
      if (words.size() == 0) begin
        m_st = 3;
        hist.delete();
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_a(input string tag);
    logic [31:0] ed;
    logic        ev, el;
    ev = (m_st == 2);
    ed = 32'h0;
    el = 1'b0;
    if (ev) begin
      ed = words[0];
      el = (words.size() == 1);
    end
    chk({tag, ":state"}, 32'(state_o), 32'(m_st));
    chk({tag, ":rd_valid"}, 32'(rd_valid), 32'(ev));
    chk({tag, ":rd_last"}, 32'(rd_last), 32'(el));
    chk({tag, ":rd_data"}, rd_data, ed);
    if (m_st != 2 || m_acc == 0)
      chk({tag, ":count"}, 32'(count_o), 32'(hist.size()));
  endtask

  task automatic tick(input string tag);
    if (!rst_n) model_reset();
    else model_step();
    @(posedge clk);
    #1;
    check_a(tag);
  endtask

  task automatic cap(input logic [31:0] inst, input string tag);
    cap_valid = 1'b1;
    cap_inst = inst;
    cap_alu_out = $urandom;
    cap_write_reg = 5'($urandom);
    cap_reg_write = 1'($urandom);
    tick(tag);
    cap_valid = 1'b0;
  endtask

  logic [31:0] s2_alu [20];
  logic [4:0]  s2_wr  [20];
  logic        s2_rw  [20];
  logic        pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    int n, e, w;
    logic [31:0] exp;
    checks = 0; errors = 0;
    model_reset();

    // reset
    repeat (2) tick("reset");
    chk("reset_b_valid", 32'(b_rd_valid), 32'd0);
    chk("reset_b_state", 32'(b_state), 32'd0);
    rst_n = 1'b1;

    // basic trigger with two post captures, stalling readout
    trig_inst = 32'h102;
    trig_mask = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) cap(32'h100 + i, "s1cap");
    chk("s1_drain_state", 32'(state_o), 32'd2);
    chk("s1_first_inst", rd_data, 32'h100);
    n = 0;
    for (int k = 0; k < 200 && m_st == 2; k++) begin
      rd_ready = pat[k % 4];
      if (rd_ready) n++;
      tick("s1rd");
    end
    rd_ready = 1'b0;
    chk("s1_words", 32'(n), 32'(5 * WPE));
    chk("s1_done", 32'(state_o), 32'd3);
    for (int k = 0; k < 4; k++) begin
      rd_ready = 1'b1;
      cap_valid = 1'b1;
      cap_inst = 32'h102;
      tick("done_hold");
    end
    cap_valid = 1'b0;
    rd_ready = 1'b0;

    // wraparound, both trigger depths
    arm = 1'b1; tick("arm2"); arm = 1'b0;
    chk("arm2_state", 32'(state_o), 32'd0);
    chk("arm2_count", 32'(count_o), 32'd0);
    trig_inst = 32'h13;
    for (int i = 0; i < 20; i++) begin
      cap(32'(i), "s2cap");
      s2_alu[i] = cap_alu_out;
      s2_wr[i]  = cap_write_reg;
      s2_rw[i]  = cap_reg_write;
    end
    chk("s2_b_state", 32'(b_state), 32'd2);
    chk("s2_b_count", 32'(b_count), 32'd16);
    chk("s2_a_state", 32'(state_o), 32'd1);
    rd_ready = 1'b1;
    for (int k = 0; k < 16 * WPE; k++) begin
      e = 4 + k / WPE;
      w = k % WPE;
      if (w == 0) exp = 32'(e);
      else if (w == 1) exp = s2_alu[e];
      else exp = {26'b0, s2_rw[e], s2_wr[e]};
      if (w < 3) chk("s2_b_data", b_rd_data, exp);
      chk("s2_b_last", 32'(b_rd_last), 32'(k == 16 * WPE - 1));
      tick("s2_bdrain");
    end
    rd_ready = 1'b0;
    chk("s2_b_done", 32'(b_state), 32'd3);
    chk("s2_b_count0", 32'(b_count), 32'd0);
    cap(32'h14, "s2post");
    cap(32'h15, "s2post");
    chk("s2_a_count", 32'(count_o), 32'd16);
    chk("s2_a_oldest", rd_data, 32'h6);
    for (int k = 0; k < 400 && m_st == 2; k++) begin
      rd_ready = 1'($urandom);
      tick("s2rd");
    end
    rd_ready = 1'b0;
    chk("s2_a_done", 32'(state_o), 32'd3);

    // retrigger ignored in POST, cap_valid gaps, arm mid-drain
    arm = 1'b1; tick("arm3"); arm = 1'b0;
    trig_inst = 32'h200;
    cap(32'h300, "s5cap");
    cap(32'h301, "s5cap");
    cap(32'h200, "s5trig");
    repeat (3) tick("s5gap");
    chk("s5_post1", 32'(state_o), 32'd1);
    cap(32'h200, "s5retrig");
    chk("s5_post2", 32'(state_o), 32'd1);
    repeat (3) tick("s5gap");
    cap(32'h302, "s5last");
    chk("s5_drain", 32'(state_o), 32'd2);
    chk("s5_count", 32'(count_o), 32'd5);
    rd_ready = 1'b1;
    repeat (4) tick("s5rd");
    arm = 1'b1;
    cap_valid = 1'b1;
    cap_inst = 32'h200;
    tick("s5arm");
    arm = 1'b0;
    cap_valid = 1'b0;
    rd_ready = 1'b0;
    chk("s5_arm_state", 32'(state_o), 32'd0);
    chk("s5_arm_count", 32'(count_o), 32'd0);
    chk("s5_arm_valid", 32'(rd_valid), 32'd0);

    // random traffic
    trig_inst = $urandom;
    trig_mask = 32'hF;
    for (int k = 0; k < 1500; k++) begin
      arm = ($urandom_range(0, 199) == 0);
      cap_valid = 1'($urandom);
      cap_inst = $urandom;
      cap_alu_out = $urandom;
      cap_write_reg = 5'($urandom);
      cap_reg_write = 1'($urandom);
      rd_ready = 1'($urandom);
      tick("rand");
    end
    arm = 1'b0; cap_valid = 1'b0; rd_ready = 1'b0;

    // reset during readout
    arm = 1'b1; tick("arm4"); arm = 1'b0;
    trig_mask = 32'h0;
    for (int i = 0; i < 3; i++) cap(32'h400 + i, "s7cap");
    chk("s7_drain", 32'(state_o), 32'd2);
    rd_ready = 1'b1;
    repeat (2) tick("s7rd");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("s7_rst_valid", 32'(rd_valid), 32'd0);
    chk("s7_rst_data", rd_data, 32'd0);
    chk("s7_rst_state", 32'(state_o), 32'd0);
    chk("s7_rst_count", 32'(count_o), 32'd0);
    tick("s7inrst");
    rst_n = 1'b1;
    repeat (4) tick("s7after");
    rd_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/debug_trace_buffer.md
DEBUG_TRACE_BUFFER -- requirements
Module: debug_trace_buffer

Interface
REQ-001 Parameter DEPTH, default 16, ring-buffer entries; SHALL be a power of two, 2 to 256.
REQ-002 Parameter POST_TRIG, default 8, captures recorded after the trigger entry; range 0 to DEPTH-1.
REQ-003 clk  in  1  single clock; all state SHALL update on posedge clk.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 cap_valid  in  1  writeback-side snapshot valid this cycle.
REQ-006 cap_inst  in  32  instruction word of the snapshot.
REQ-007 cap_alu_out  in  32  execute-stage ALU result.
REQ-008 cap_write_reg  in  5  destination register.
REQ-009 cap_reg_write  in  1  register-write enable.
REQ-010 trig_inst / trig_mask  in  32 each  trigger when (cap_inst & trig_mask) == (trig_inst & trig_mask).
REQ-011 arm  in  1  single-cycle pulse; clears buffer and re-arms.
REQ-012 rd_valid / rd_data / rd_last  out  1/32/1  readout word, valid, final-word flag.
REQ-013 rd_ready  in  1  readout consumer accept.
REQ-014 state_o  out  2  current FSM state; count_o  out  $clog2(DEPTH)+1  entries held.

Function
REQ-015 FSM states SHALL be ARMED=0, POST=1, DRAIN=2, DONE=3.
REQ-016 ARMED: each cap_valid cycle SHALL write one entry at the write pointer; the pointer SHALL wrap modulo DEPTH, and the oldest entry SHALL be overwritten when full.
REQ-017 count_o SHALL increment per capture and saturate at DEPTH.
REQ-018 ARMED with cap_valid and trigger match: the entry SHALL be captured; the next state SHALL be POST, or DRAIN if POST_TRIG=0.
REQ-019 POST: each cap_valid cycle SHALL capture and decrement a post counter; the capture that reaches zero SHALL move to DRAIN.
REQ-020 Trigger matches in POST SHALL be ignored; cap_valid=0 cycles SHALL not capture or decrement.
REQ-021 DRAIN: no capture; entries SHALL be emitted oldest-first; each entry is 3 words: cap_inst, cap_alu_out, {26'b0, cap_reg_write, cap_write_reg}.
REQ-022 rd_valid SHALL equal (state==DRAIN); a word SHALL advance only on rd_valid && rd_ready; rd_data SHALL hold stable while rd_valid && !rd_ready.
REQ-023 rd_last SHALL be high only on the final word of the newest entry.
REQ-024 Acceptance of the rd_last word SHALL move to DONE with count_o=0; DONE SHALL hold until arm.
REQ-025 arm in any state SHALL, next cycle, set ARMED, count_o=0, pointers=0; arm SHALL take priority over a same-cycle capture, trigger, or read handshake.
REQ-026 rd_data SHALL be 0 when rd_valid is low.

Reset
REQ-027 rst_n low SHALL immediately force state ARMED, count_o=0, all pointers and counters 0, rd_valid=0, rd_last=0, rd_data=0; buffer contents need not be cleared.
REQ-028 Reset mid-DRAIN SHALL abandon the readout with no further rd_valid.

Configuration
REQ-029 With DEBUG_TRACE_TIMESTAMP_EN defined, a 32-bit free-running cycle counter (reset 0, wraps) SHALL be stored per entry as a 4th readout word, after word 3; rd_last then marks that 4th word.
REQ-030 Without DEBUG_TRACE_TIMESTAMP_EN, entries SHALL be 3 words and no counter SHALL exist.

Structure
REQ-031 A shared package debug_trace_pkg SHALL hold the state enum, the packed entry struct (inst, alu_out, write_reg, reg_write, optional timestamp), and WORDS_PER_ENTRY (3 or 4).
REQ-032 Storage SHALL be one sub-module trace_ring_ram: DEPTH x entry width, one synchronous write port, one read port; readout latency SHALL be hidden so rd_valid never drops mid-DRAIN.

Verification
REQ-033 DEPTH=16, POST_TRIG=2; captures inst=0x100..0x104, trigger mask=0xFFFFFFFF on 0x102 -> DRAIN after 0x104; 15 words, inst order 0x100..0x104, rd_last on word 15.
REQ-034 20 captures 0x0..0x13 before trigger on 0x13, POST_TRIG=0 -> count_o=16; readout starts inst 0x4, ends 0x13.
REQ-035 DRAIN with rd_ready toggling 1,0,0,1 -> rd_data constant across stall cycles; no word lost or duplicated.
REQ-036 arm pulse during word 5 of DRAIN -> next cycle state_o=0, count_o=0, rd_valid=0.
REQ-037 Trigger inst matches again during POST, and cap_valid gaps of 3 cycles -> exactly POST_TRIG captures after the trigger; second match ignored.
REQ-038 With DEBUG_TRACE_TIMESTAMP_EN, captures on cycles 10 and 12 -> 4th words 10 and 12; rd_last on word 8.
